// File: rtl/bpsk_audio_tx_if.sv
// Byte-source and codec-write signals of the BPSK audio transmitter.
interface bpsk_audio_tx_if;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               write_ready;
  logic               write;
  logic signed [23:0] writedata_left;
  logic signed [23:0] writedata_right;
  logic               busy;

  // Byte source / codec side (drives the transmitter).
  modport master (
    output tx_data, tx_valid, write_ready,
    input  tx_ready, write, writedata_left, writedata_right, busy
  );

  // Transmitter side.
  modport slave (
    input  tx_data, tx_valid, write_ready,
    output tx_ready, write, writedata_left, writedata_right, busy
  );
endinterface

// File: rtl/bpsk_audio_tx.sv
// BPSK audio transmitter: frames bytes (preamble, sync, payload, zero tail) into
// +/-AMPLITUDE symbols held for SPB samples each, streamed into the codec FIFO.
module bpsk_audio_tx #(
  parameter int unsigned        SPB          = 64,
  parameter logic signed [23:0] AMPLITUDE    = 24'sh100000,
  parameter int unsigned        PRE_BITS     = 16,
  parameter logic [7:0]         SYNC_BYTE    = 8'h7E,
  parameter int unsigned        TAIL_SAMPLES = 64
) (
  input logic           CLOCK_50,
  input logic           reset,
  bpsk_audio_tx_if.slave bus
);

  localparam int unsigned CntW   = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int unsigned BitMax = (PRE_BITS > 8) ? PRE_BITS : 8;
  localparam int unsigned BitW   = $clog2(BitMax + 1);
  localparam int unsigned TailW  = (TAIL_SAMPLES > 1) ? $clog2(TAIL_SAMPLES) : 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(SPB - 1);
  localparam logic [BitW-1:0]  PreLast  = BitW'(PRE_BITS - 1);
  localparam logic [BitW-1:0]  ByteLast = BitW'(7);
  localparam logic [TailW-1:0] TailLast = TailW'(TAIL_SAMPLES - 1);

  localparam logic signed [23:0] LevelPos = AMPLITUDE;
  localparam logic signed [23:0] LevelNeg = -AMPLITUDE;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPre  = 3'd1;
  localparam logic [2:0] StSync = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StTail = 3'd4;

  logic [2:0]         state;
  logic [7:0]         hold;
  logic               hold_valid;
  logic [CntW-1:0]    sample_cnt;
  logic [BitW-1:0]    bit_cnt;
  logic [TailW-1:0]   tail_cnt;
  logic [7:0]         shift;
  logic signed [23:0] level;

  logic write;
  logic adv;
  logic bit_last;
  logic accept;
  logic load;

  // Handshake decode: sample pushes, bit boundaries, byte accept and load.
  always_comb begin
    write    = bus.write_ready & ~reset;
    adv      = write & bus.write_ready;
    bit_last = (sample_cnt == CntLast);
    accept   = bus.tx_valid & ~hold_valid;
    load     = adv & bit_last & (bit_cnt == ByteLast) & hold_valid &
               ((state == StSync) | (state == StData));
  end

  // Holding register; a load needs hold_valid=1 so it never meets an accept.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold       <= 8'h00;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold       <= bus.tx_data;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  // Frame sequencer; level registers the value of the sample consumed by each adv.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= StIdle;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      tail_cnt   <= '0;
      shift      <= 8'h00;
      level      <= '0;
    end else if (adv) begin
      case (state)
        StIdle: begin
          if (hold_valid) begin
            // This sample is already the first one of preamble bit 0.
            state      <= StPre;
            sample_cnt <= CntW'(1);
            bit_cnt    <= '0;
            level      <= LevelPos;
          end else begin
            level <= '0;
          end
        end
        StPre: begin
          level <= bit_cnt[0] ? LevelNeg : LevelPos;
          if (bit_last) begin
            sample_cnt <= '0;
            if (bit_cnt == PreLast) begin
              state   <= StSync;
              bit_cnt <= '0;
              shift   <= SYNC_BYTE;
            end else begin
              bit_cnt <= bit_cnt + BitW'(1);
            end
          end else begin
            sample_cnt <= sample_cnt + CntW'(1);
          end
        end
        StSync, StData: begin
          level <= shift[7] ? LevelPos : LevelNeg;
          if (bit_last) begin
            sample_cnt <= '0;
            if (bit_cnt == ByteLast) begin
              bit_cnt <= '0;
              if (hold_valid) begin
                state <= StData;
                shift <= hold;
              end else begin
                state    <= StTail;
                tail_cnt <= '0;
              end
            end else begin
              bit_cnt <= bit_cnt + BitW'(1);
              shift   <= {shift[6:0], 1'b0};
            end
          end else begin
            sample_cnt <= sample_cnt + CntW'(1);
          end
        end
        StTail: begin
          level <= '0;
          if (tail_cnt == TailLast) begin
            state <= StIdle;
          end else begin
            tail_cnt <= tail_cnt + TailW'(1);
          end
        end
        default: begin
          state <= StIdle;
          level <= '0;
        end
      endcase
    end
  end

  assign bus.write           = write;
  assign bus.writedata_left  = level;
  assign bus.writedata_right = level;
  assign bus.tx_ready        = ~hold_valid;
  assign bus.busy            = (state != StIdle);

endmodule

// File: tb/tb_bpsk_audio_tx.sv
// Scoreboard bench for bpsk_audio_tx: stimulus pushes expected sample streams,
// a negedge monitor pops and compares every pushed codec sample.
module tb_bpsk_audio_tx;
  localparam int unsigned SPB  = 4;
  localparam int unsigned PRE  = 4;
  localparam int unsigned TAIL = 4;
  localparam logic signed [23:0] A = 24'sh100000;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  bpsk_audio_tx_if bus();

  bpsk_audio_tx #(
    .SPB         (SPB),
    .AMPLITUDE   (A),
    .PRE_BITS    (PRE),
    .SYNC_BYTE   (8'h7E),
    .TAIL_SAMPLES(TAIL)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks   = 0;
  int n_fail     = 0;
  int wr_cnt     = 0;
  int busy_cnt   = 0;
  int hunt_skip  = 0;
  int sample_idx = 0;
  bit mon_en     = 1'b0;
  bit hunt       = 1'b0;
  bit rdy_toggle = 1'b0;
  logic signed [23:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_lvl(input logic b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b ? A : -A);
  endtask

  task automatic push_zero(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(24'sd0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) push_lvl(b[i], SPB);
  endtask

  task automatic push_frame_head();
    for (int i = 0; i < PRE; i++) push_lvl((i % 2) == 0, SPB);
    push_byte(8'h7E);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge CLOCK_50);
    while (!bus.tx_ready && t < 2000) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (t >= 2000) check("send_timeout", 1, 0);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  // Returns at the negedge where tx_ready is next seen high.
  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge CLOCK_50);
    while (!bus.tx_ready && t < 2000) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("ready_timeout", (t >= 2000), 0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    @(negedge CLOCK_50);
    while ((exp_q.size() != 0 || hunt || bus.busy) && t < 4000) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("drain_timeout", (t >= 4000), 0);
  endtask

  // write_ready source: constant 1, or toggling every cycle.
  initial begin
    bus.write_ready = 1'b1;
    forever begin
      @(posedge CLOCK_50);
      #1;
      bus.write_ready = rdy_toggle ? ~bus.write_ready : 1'b1;
    end
  end

  // Monitor: compares every pushed sample against the scoreboard queue.
  initial begin
    logic signed [23:0] exp_s;
    forever begin
      @(negedge CLOCK_50);
      if (bus.busy) busy_cnt++;
      if (mon_en) begin
        if (!bus.write_ready) check("write_gated", bus.write, 0);
        if (bus.write) begin
          wr_cnt++;
          check("left_eq_right", bus.writedata_left, bus.writedata_right);
          if (hunt && bus.writedata_left == 24'sd0) begin
            hunt_skip++;
            if (hunt_skip > 400) begin
              check("frame_start_timeout", 1, 0);
              hunt = 1'b0;
            end
          end else begin
            hunt  = 1'b0;
            exp_s = 24'sd0;
            if (exp_q.size() > 0) exp_s = exp_q.pop_front();
            check($sformatf("sample[%0d]", sample_idx), bus.writedata_left, exp_s);
            sample_idx++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int w0;
    int low_bad;
    int n_idle;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset_writedata", bus.writedata_left, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_write", bus.write, 0);
    check("reset_tx_ready", bus.tx_ready, 1);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // Single byte A5 with constant write_ready.
    mon_en = 1'b1;
    hunt_skip = 0;
    hunt = 1'b1;
    push_frame_head();
    push_byte(8'hA5);
    push_zero(TAIL);
    b0 = busy_cnt;
    send_byte(8'hA5);
    wait_drain();
    check("busy_cycles_a5", busy_cnt - b0, 83);

    // Back-to-back FF, 00: second byte offered at the start of the first DATA byte.
    hunt_skip = 0;
    hunt = 1'b1;
    push_frame_head();
    push_byte(8'hFF);
    push_byte(8'h00);
    push_zero(TAIL);
    send_byte(8'hFF);
    wait_ready();
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.tx_valid = 1'b0;
    low_bad = 0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge CLOCK_50);
      if (bus.tx_ready) low_bad++;
    end
    check("tx_ready_low_window", low_bad, 0);
    @(negedge CLOCK_50);
    check("tx_ready_after_load", bus.tx_ready, 1);
    wait_drain();

    // Idle stream: 100 zero samples, not busy.
    @(posedge CLOCK_50);
    #1;
    w0 = wr_cnt;
    repeat (100) @(posedge CLOCK_50);
    #1;
    check("idle_writes", wr_cnt - w0, 100);
    check("idle_busy", bus.busy, 0);

    // Byte 81 with write_ready toggling every cycle.
    rdy_toggle = 1'b1;
    hunt_skip = 0;
    hunt = 1'b1;
    push_frame_head();
    push_byte(8'h81);
    push_zero(TAIL);
    b0 = busy_cnt;
    send_byte(8'h81);
    wait_drain();
    check("busy_cycles_toggle", busy_cnt - b0, 166);
    rdy_toggle = 1'b0;
    repeat (3) @(posedge CLOCK_50);

    // Second byte offered during TAIL: new frame with full preamble.
    hunt_skip = 0;
    hunt = 1'b1;
    push_frame_head();
    push_byte(8'hC3);
    push_zero(TAIL);
    push_frame_head();
    push_byte(8'h3C);
    push_zero(TAIL);
    send_byte(8'hC3);
    wait_ready();
    repeat (33) @(posedge CLOCK_50);
    #1;
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.tx_valid = 1'b0;
    n_idle = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLOCK_50);
      if (!bus.busy) n_idle++;
      else if (n_idle > 0) break;
    end
    check("idle_gap_cycles", n_idle, 1);
    wait_drain();

    // Reset during DATA bit 3 with a byte held.
    mon_en = 1'b0;
    hunt = 1'b0;
    exp_q.delete();
    send_byte(8'h5A);
    wait_ready();
    bus.tx_data  = 8'hE7;
    bus.tx_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.tx_valid = 1'b0;
    check("held_before_reset", bus.tx_ready, 0);
    repeat (12) @(negedge CLOCK_50);
    check("busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check("rst_mid_writedata", bus.writedata_left, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_tx_ready", bus.tx_ready, 1);
    check("rst_mid_write", bus.write, 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    mon_en = 1'b1;
    b0 = busy_cnt;
    repeat (200) @(posedge CLOCK_50);
    #1;
    check("held_byte_discarded", busy_cnt - b0, 0);
    check("queue_empty_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
